// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply-divide unit with HI/LO result registers.
// Latency WIDTH+2 edges (2 for divide-by-zero); define MULDIV_EARLY_OUT_EN to end MULT/MULTU early.
// No backpressure: start is ignored while busy, so callers must wait for done.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
   state_t state, state_nxt;

   logic               div_q, neg_res, neg_rem, dz_q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] pacc;   // product, or {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] mcand;  // shifting multiplicand; raw dividend for divide-by-zero
   logic [WIDTH-1:0]   opb;    // shifting multiplier, or fixed divisor magnitude

   logic               a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] mul_sum, prod_fix;
   logic [WIDTH:0]     div_shift, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem, quot_fix, rem_fix;
   logic               mul_last, last_iter, load, move_ok;

   always_comb begin
      a_neg     = ~op[0] & a[WIDTH-1];
      b_neg     = ~op[0] & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      b_zero    = (b == '0);
      mul_sum   = pacc + (opb[0] ? mcand : '0);
      // restoring step: the partial remainder is always below the divisor, so W+1 bits suffice
      div_shift = {pacc[2*WIDTH-1:WIDTH], pacc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb});
      div_diff  = div_shift - {1'b0, opb};
      div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      prod_fix  = neg_res ? -pacc : pacc;
      quot_fix  = neg_res ? -pacc[WIDTH-1:0] : pacc[WIDTH-1:0];
      rem_fix   = neg_rem ? -pacc[2*WIDTH-1:WIDTH] : pacc[2*WIDTH-1:WIDTH];
   end

`ifdef MULDIV_EARLY_OUT_EN
   // stop once the multiplier bits still to be consumed are all zero
   assign mul_last = (cnt == CW'(WIDTH-1)) || (opb[WIDTH-1:1] == '0);
`else
   assign mul_last = (cnt == CW'(WIDTH-1));
`endif

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      move_ok   = 1'b0;
      last_iter = div_q ? (cnt == CW'(WIDTH-1)) : mul_last;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = (op[1] && b_zero) ? FIX : RUN;
            end else begin
               move_ok = 1'b1;
            end
         end
         RUN:     if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q   <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         dz_q    <= 1'b0;
         cnt     <= '0;
         pacc    <= '0;
         mcand   <= '0;
         opb     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         divzero <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         busy    <= (state_nxt != IDLE);
         done    <= (state == FIX);
         divzero <= (state == FIX) && dz_q;
         if (load) begin
            div_q   <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz_q    <= op[1] & b_zero;
            cnt     <= '0;
            opb     <= b_mag;
            if (op[1]) begin
               pacc  <= {{WIDTH{1'b0}}, a_mag};
               mcand <= {{WIDTH{1'b0}}, a};
            end else begin
               pacc  <= '0;
               mcand <= {{WIDTH{1'b0}}, a_mag};
            end
         end
         if (state == RUN) begin
            cnt <= cnt + CW'(1);
            if (div_q) begin
               pacc <= {div_rem, pacc[WIDTH-2:0], div_ge};
            end else begin
               pacc  <= mul_sum;
               mcand <= mcand << 1;
               opb   <= opb >> 1;
            end
         end
         if (state == FIX) begin
            if (dz_q) begin
               hi <= mcand[WIDTH-1:0];
               lo <= '1;
            end else if (div_q) begin
               hi <= rem_fix;
               lo <= quot_fix;
            end else begin
               hi <= prod_fix[2*WIDTH-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end
         end
         if (move_ok && mthi) hi <= wdata;
         if (move_ok && mtlo) lo <= wdata;
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus random ops checked against a 64-bit arithmetic model.
module tb_mul_div_unit;
   logic        clk, reset, start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done, divzero;
   logic [31:0] hi, lo;
   int          ncmp, nfail;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected result straight from the arithmetic definition of each op.
   function automatic void model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] eh, output logic [31:0] el,
                                 output logic edz, output int eedges);
      longint sa, sb, p, q, r, mb;
      int     iters;
      sa = o[0] ? longint'(av) : longint'(int'(av));
      sb = o[0] ? longint'(bv) : longint'(int'(bv));
      edz = 1'b0;
      if (!o[1]) begin
         p  = sa * sb;
         eh = p[63:32];
         el = p[31:0];
         iters = 32;
`ifdef MULDIV_EARLY_OUT_EN
         mb = (sb < 0) ? -sb : sb;
         iters = 1;
         for (int i = 0; i < 32; i++) if (mb[i]) iters = i + 1;
`else
         mb = 0;
`endif
         eedges = iters + 1;
      end else if (bv == 32'd0) begin
         eh = av; el = 32'hFFFF_FFFF; edz = 1'b1; eedges = 1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         eh = r[31:0];
         el = q[31:0];
         eedges = 33;
      end
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv, input bit poke);
      logic [31:0] eh, el, hi0, lo0;
      logic        edz;
      int          eedges, edges;
      bit          got, held;
      model(o, av, bv, eh, el, edz, eedges);
      hi0 = hi; lo0 = lo;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      if (poke) begin mthi = 1'b1; wdata = 32'hDEAD_BEEF; end
      @(posedge clk); #1;
      chk("busy_rise", busy, 1);
      chk("done_one_cycle", done, 0);
      edges = 0; got = 0; held = 1;
      while (!got && edges < 40) begin
         @(negedge clk);
         start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
         a = $urandom; b = $urandom; op = 2'($urandom);
         if (poke && edges == 4) begin
            start = 1'b1; op = 2'b11; b = 32'd0; mtlo = 1'b1; wdata = 32'hBAD0_0BAD;
         end
         @(posedge clk); #1;
         edges++;
         if (done) got = 1;
         else if (hi !== hi0 || lo !== lo0) held = 0;
      end
      start = 1'b0; mtlo = 1'b0;
      chk("latency", edges, eedges);
      chk("hilo_hold", held, 1);
      chk("busy_fall", busy, 0);
      chk("hi", hi, eh);
      chk("lo", lo, el);
      chk("divzero", divzero, edz);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [31:0] edges_s [3];
      ncmp = 0; nfail = 0;
      reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_divzero", divzero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      @(negedge clk) reset = 1'b1;

      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFEB);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd7, 32'd2, 0);
      chk("divu_lo", lo, 32'd3);
      chk("divu_hi", hi, 32'd1);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("divmin_lo", lo, 32'h8000_0000);
      chk("divmin_hi", hi, 32'h0);
      run_op(2'b11, 32'd5, 32'd0, 0);
      chk("dz_hi", hi, 32'd5);
      chk("dz_lo", lo, 32'hFFFF_FFFF);
      run_op(2'b01, 32'd3, 32'd5, 0);
      chk("eo_lo15", lo, 32'd15);
      run_op(2'b01, 32'd9, 32'd0, 0);
      chk("eo_lo0", lo, 32'd0);
      // start and mthi together, then start/mtlo pokes while busy
      run_op(2'b00, 32'd12345, 32'h8000_0001, 1);

      @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
      edges_s[0] = lo;
      @(posedge clk); #1;
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo_kept", lo, edges_s[0]);
      @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
      @(posedge clk); #1;
      chk("mtlo_lo", lo, 32'h5678);
      @(negedge clk); mtlo = 1'b0;

      // reset in the middle of a multiply
      @(negedge clk); start = 1'b1; op = 2'b01; a = 32'h1111_1111; b = 32'hFFFF_FFFF;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_hi", hi, 0);
      chk("mid_rst_lo", lo, 0);
      @(negedge clk) reset = 1'b1;
      run_op(2'b01, 32'd2, 32'd3, 0);
      chk("post_rst_lo", lo, 32'd6);

      edges_s[0] = 32'h8000_0000; edges_s[1] = 32'hFFFF_FFFF; edges_s[2] = 32'd1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(0, 20);
            2:       rb = edges_s[$urandom_range(0, 2)];
            default: rb = $urandom;
         endcase
         ra = ($urandom_range(0, 4) == 0) ? edges_s[$urandom_range(0, 2)] : $urandom;
         run_op(2'($urandom), ra, rb, 0);
      end
      @(posedge clk); #1;
      chk("done_fall", done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
